mult32x32_req_if: RTL and testbench
===================================

// Module: mult32x32_req_if
// PURPOSE
// - Upstream request/response front-end for the 32x32 sequential multiplier (FSM + datapath pair).
// - Accepts operand pairs on a valid/ready port and buffers them in a small FIFO.
// - Launches one multiply at a time via start/busy, holding a/b stable for the whole run.
// - Captures the 64-bit product into a result register presented on a valid/ready port.
// PARAMETERS
// - FIFO_DEPTH   2   operand FIFO entries; power of 2, >=2
// - TAG_W        4   width of user tag carried from request to response
// - TIMEOUT_CYC  16  watchdog limit in cycles (used only with MULT_REQ_TIMEOUT_EN)
// PORTS
// - clk          in   1      single clock, all state on posedge
// - reset        in   1      asynchronous, active-low reset
// - in_valid     in   1      request valid
// - in_ready     out  1      FIFO not full
// - in_a         in   32     operand A
// - in_b         in   32     operand B
// - in_tag       in   TAG_W  request tag
// - start        out  1      one-cycle launch pulse to multiplier FSM
// - a            out  32     operand A to datapath (FIFO head, stable while in flight)
// - b            out  32     operand B to datapath (FIFO head, stable while in flight)
// - busy         in   1      multiplier busy
// - product      in   64     multiplier product register
// - out_valid    out  1      result valid
// - out_ready    in   1      result consumer ready
// - out_product  out  64     captured product
// - out_tag      out  TAG_W  tag of captured request
// - err          out  1      sticky timeout flag (0 when feature compiled out)
// BEHAVIOUR
// - Reset (reset=0): FIFO empty, state IDLE; in_ready=1, start=0, a=b=0, out_valid=0,
//   out_product=0, out_tag=0, err=0. Reset mid-run abandons the operation; no result emitted.
// - FIFO: push on in_valid&&in_ready; pop on capture only. Push/pop in the same cycle allowed
//   when full (pop frees the slot, push succeeds; count unchanged). Pointers wrap mod FIFO_DEPTH.
// - a/b/tag are always driven from the FIFO head; a=b=0 when empty.
// - States:
//   IDLE:   FIFO non-empty && out_valid==0 -> LAUNCH.
//   LAUNCH: start=1 for exactly one cycle -> WAIT_HI.
//   WAIT_HI: busy==1 -> WAIT_LO.
//   WAIT_LO: first cycle busy sampled 0 -> capture product, head tag into out regs,
//            out_valid<=1, pop FIFO -> IDLE.
// - Latency: in_valid accept to start = 2 cycles (FIFO write, IDLE decision); start to
//   out_valid = multiplier run length + 2 cycles.
// - Result slot: out_valid held with out_product/out_tag stable until out_valid&&out_ready.
//   No new launch while out_valid=1 (strictly one result in the slot, no overwrite).
// - Same-cycle out handshake and IDLE launch check: IDLE sees out_valid as registered, so
//   the next launch occurs the cycle after consumption.
// - product is not sign-interpreted; 64-bit unsigned capture, no truncation.
// - busy changes outside WAIT_HI/WAIT_LO are ignored.
// CONFIGURATION
// - MULT_REQ_TIMEOUT_EN defined: cycle counter runs in WAIT_HI/WAIT_LO, cleared in LAUNCH.
//   Reaching TIMEOUT_CYC -> err<=1 (sticky until reset), FIFO head popped, no result written,
//   state -> IDLE.
// - Not defined: no counter; err tied to 0; FSM waits indefinitely for busy.
// TESTING
// - Single req a=3, b=5, tag=1 -> one start pulse; out_product=64'd15, out_tag=1, err=0.
// - a=b=32'hFFFF_FFFF -> out_product=64'hFFFF_FFFE_0000_0001.
// - Push 3 reqs back-to-back, FIFO_DEPTH=2 -> in_ready=0 after 2nd; results in order, tags 0,1,2.
// - Hold out_ready=0 for 20 cycles after out_valid -> no 2nd start; out data stable.
// - Assert reset low while in WAIT_LO -> all outputs at reset values next edge, no out_valid.
// - MULT_REQ_TIMEOUT_EN, busy stuck 0 after start -> err=1 at TIMEOUT_CYC, FIFO pops, no out_valid.

Source files
------------

// File: rtl/mult32x32_req_if.sv
// mult32x32_req_if
// Request/response front-end for the 32x32 sequential multiplier.
// Operand pairs arrive on a valid/ready port and are queued in a small FIFO.
// One multiply at a time is launched with start/busy, with a/b driven from the
// FIFO head. The 64-bit product is captured into a single result slot that is
// offered on a valid/ready port.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. A valid source holds its data stable until that edge, and ready
// never waits for valid.
//
// Build option: define MULT_REQ_TIMEOUT_EN to add a watchdog. It counts cycles
// spent waiting for the multiplier. At TIMEOUT_CYC it drops the head request
// and sets the sticky err flag. Without the define, err is tied to 0.
//
// dbg_state exposes the control FSM state for debug and checkers.

module mult32x32_req_if #(
    parameter int FIFO_DEPTH  = 2,
    parameter int TAG_W       = 4,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             start,
    output logic [31:0]      a,
    output logic [31:0]      b,
    input  logic             busy,
    input  logic [63:0]      product,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_product,
    output logic [TAG_W-1:0] out_tag,
    output logic             err,
    output logic [1:0]       dbg_state
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LAUNCH  = 2'd1,
        S_WAIT_HI = 2'd2,
        S_WAIT_LO = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [31:0]      a_mem   [FIFO_DEPTH];
    logic [31:0]      b_mem   [FIFO_DEPTH];
    logic [TAG_W-1:0] tag_mem [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic fifo_empty;
    logic fifo_full;
    logic push;
    logic pop;
    logic capture;
    logic tmo_fire;
    logic tmo_hit;
    logic [TAG_W-1:0] head_tag;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));

    // The head entry leaves only when its run ends, by capture or by timeout.
    // A pop frees a slot in the same cycle, so a full FIFO can still accept.
    assign pop      = capture | tmo_fire;
    assign in_ready = !fifo_full || pop;
    assign push     = in_valid && in_ready;

    // The head entry stays put while the run is in flight, so a/b are stable.
    assign a        = fifo_empty ? '0 : a_mem[rd_ptr];
    assign b        = fifo_empty ? '0 : b_mem[rd_ptr];
    assign head_tag = fifo_empty ? '0 : tag_mem[rd_ptr];

    assign dbg_state = state;

    // FIFO storage; contents are qualified by count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            a_mem[wr_ptr]   <= in_a;
            b_mem[wr_ptr]   <= in_b;
            tag_mem[wr_ptr] <= in_tag;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally (depth is a power of 2).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // FSM next state and control strobes.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        capture   = 1'b0;
        tmo_fire  = 1'b0;
        case (state)
            S_IDLE: begin
                // out_valid is the registered value, so a launch waits one
                // cycle after the slot is drained.
                if (!fifo_empty && !out_valid) state_nxt = S_LAUNCH;
            end
            S_LAUNCH: begin
                start     = 1'b1;
                state_nxt = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (tmo_hit) begin
                    tmo_fire  = 1'b1;
                    state_nxt = S_IDLE;
                end else if (busy) begin
                    state_nxt = S_WAIT_LO;
                end
            end
            S_WAIT_LO: begin
                // A completion seen in the same cycle as the timeout still counts.
                if (!busy) begin
                    capture   = 1'b1;
                    state_nxt = S_IDLE;
                end else if (tmo_hit) begin
                    tmo_fire  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Single result slot: filled on capture, emptied on the output handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid   <= 1'b0;
            out_product <= '0;
            out_tag     <= '0;
        end else if (capture) begin
            out_valid   <= 1'b1;
            out_product <= product;
            out_tag     <= head_tag;
        end else if (out_valid && out_ready) begin
            out_valid   <= 1'b0;
        end
    end

`ifdef MULT_REQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             err_q;

    assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
    assign err     = err_q;

    // Watchdog: counts waiting cycles of the current run; err is sticky until reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state == S_LAUNCH) begin
                tmo_cnt <= '0;
            end else if (state == S_WAIT_HI || state == S_WAIT_LO) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
            if (tmo_fire) err_q <= 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_mult32x32_req_if.sv
// tb_mult32x32_req_if
// Directed and random requests for mult32x32_req_if. A behavioural multiplier
// answers start with a random run length. Results are checked against an
// expected queue of {tag, a*b} built from the requests the bench sent.
// Define MULT_REQ_TIMEOUT_EN to add the watchdog scenario.

module tb_mult32x32_req_if;

    localparam int TAG_W       = 4;
    localparam int FIFO_DEPTH  = 2;
    localparam int TIMEOUT_CYC = 16;
    localparam int EW          = 64 + TAG_W;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic [TAG_W-1:0] in_tag;
    logic             start;
    logic [31:0]      a;
    logic [31:0]      b;
    logic             busy;
    logic [63:0]      product;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_product;
    logic [TAG_W-1:0] out_tag;
    logic             err;
    logic [1:0]       dbg_state;

    int n_asserts = 0;
    int n_fail    = 0;
    int start_cnt = 0;

    logic [EW-1:0] exp_q[$];

    // Multiplier model state
    logic        mul_stuck  = 1'b0;
    logic        mul_pend   = 1'b0;
    int          mul_rem    = 0;
    logic [31:0] mul_a      = '0;
    logic [31:0] mul_b      = '0;
    logic        rand_ready = 1'b0;

    // Monitor state
    logic          prev_hold = 1'b0;
    logic [EW-1:0] prev_data = '0;

    mult32x32_req_if #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .TAG_W      (TAG_W),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .product    (product),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_product(out_product),
        .out_tag    (out_tag),
        .err        (err),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    // ---------------- check helper ----------------
    task automatic check(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- multiplier model ----------------
    // Sees start in the launch cycle, raises busy one cycle later for a random
    // number of cycles, then presents a*b. Product is garbage while busy.
    always @(negedge clk) begin
        if (!reset) begin
            busy     = 1'b0;
            mul_pend = 1'b0;
            mul_rem  = 0;
        end else begin
            if (busy) begin
                mul_rem--;
                if (mul_rem == 0) begin
                    busy    = 1'b0;
                    product = 64'(mul_a) * 64'(mul_b);
                end else begin
                    product = {$urandom, $urandom};
                end
            end
            if (mul_pend) begin
                mul_pend = 1'b0;
                busy     = 1'b1;
                mul_rem  = $urandom_range(1, 6);
                product  = {$urandom, $urandom};
            end
            if (start && !mul_stuck) begin
                mul_pend = 1'b1;
                mul_a    = a;
                mul_b    = b;
            end
        end
    end

    // Random backpressure on the result port when enabled.
    always @(negedge clk) begin
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end

    // ---------------- scoreboard / monitor ----------------
    always begin
        @(negedge clk);
        #3;
        if (!reset) begin
            prev_hold = 1'b0;
        end else begin
            if (start) begin
                start_cnt++;
                check("no_start_while_out_valid", EW'(out_valid), EW'(0));
            end
            if (out_valid && prev_hold)
                check("out_hold_stable", {out_tag, out_product}, prev_data);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", EW'(1), EW'(0));
                end else begin
                    check("result", {out_tag, out_product}, exp_q.pop_front());
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_data = {out_tag, out_product};
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_req(input logic [31:0] pa, input logic [31:0] pb,
                            input logic [TAG_W-1:0] pt, input bit expect_res,
                            output bit first_ready);
        int  guard = 0;
        bit  acc   = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = pa;
        in_b     = pb;
        in_tag   = pt;
        #2;
        first_ready = in_ready;
        forever begin
            acc = in_ready;
            @(posedge clk);
            if (acc) break;
            guard++;
            if (guard > 500) begin
                check("push_accept_timeout", EW'(0), EW'(1));
                break;
            end
            @(negedge clk);
            #2;
        end
        if (acc && expect_res) exp_q.push_back({pt, 64'(pa) * 64'(pb)});
    endtask

    task automatic idle_in();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int guard = 0;
        while ((exp_q.size() != 0 || out_valid) && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        check(tag, EW'(exp_q.size()), EW'(0));
        repeat (3) @(negedge clk);
    endtask

    task automatic check_reset_outputs();
        check("rst_in_ready",    EW'(in_ready),    EW'(1));
        check("rst_start",       EW'(start),       EW'(0));
        check("rst_a",           EW'(a),           EW'(0));
        check("rst_b",           EW'(b),           EW'(0));
        check("rst_out_valid",   EW'(out_valid),   EW'(0));
        check("rst_out_product", EW'(out_product), EW'(0));
        check("rst_out_tag",     EW'(out_tag),     EW'(0));
        check("rst_err",         EW'(err),         EW'(0));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bit fr;
        int guard;
        int snap;
        logic [31:0] ra, rb;

        reset     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        product   = '0;
        busy      = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        #3;
        check_reset_outputs();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Single request 3*5, start latency and single pulse
        out_ready = 1'b1;
        push_req(32'd3, 32'd5, 4'd1, 1'b1, fr);
        @(negedge clk);
        in_valid = 1'b0;
        #3;
        check("start_not_before_decision", EW'(start), EW'(0));
        @(negedge clk);
        #3;
        check("start_after_two_cycles", EW'(start), EW'(1));
        @(negedge clk);
        #3;
        check("start_one_cycle_pulse", EW'(start), EW'(0));
        wait_drain("drain_single");
        check("single_product", EW'(out_product), EW'(64'd15));
        check("single_tag",     EW'(out_tag),     EW'(1));
        check("single_err",     EW'(err),         EW'(0));
        check("single_start_count", EW'(start_cnt), EW'(1));

        // All-ones operands: full 64-bit unsigned product
        push_req(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd7, 1'b1, fr);
        idle_in();
        wait_drain("drain_max");
        check("max_product", EW'(out_product), EW'(64'hFFFF_FFFE_0000_0001));

        // Three back-to-back requests: FIFO fills after two, results in order
        for (int i = 0; i < 3; i++) begin
            ra = $urandom;
            rb = $urandom;
            push_req(ra, rb, TAG_W'(i), 1'b1, fr);
            if (i == 2) check("full_after_two", EW'(fr), EW'(0));
        end
        idle_in();
        wait_drain("drain_three");
        check("three_last_tag", EW'(out_tag), EW'(2));

        // Hold the result slot: no new launch, data held stable
        out_ready = 1'b0;
        push_req($urandom, $urandom, 4'd9, 1'b1, fr);
        push_req($urandom, $urandom, 4'd10, 1'b1, fr);
        idle_in();
        guard = 0;
        while (!out_valid && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("hold_out_valid_seen", EW'(out_valid), EW'(1));
        snap = start_cnt;
        repeat (20) @(negedge clk);
        #3;
        check("hold_no_second_start", EW'(start_cnt - snap), EW'(0));
        check("hold_out_valid_kept",  EW'(out_valid),        EW'(1));
        check("hold_tag_first",       EW'(out_tag),          EW'(9));
        @(negedge clk);
        out_ready = 1'b1;
        wait_drain("drain_hold");

        // Random traffic with random backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            push_req($urandom, $urandom, TAG_W'($urandom_range(0, 15)), 1'b1, fr);
            if ($urandom_range(0, 2) == 0) begin
                idle_in();
                repeat ($urandom_range(0, 5)) @(negedge clk);
            end
        end
        idle_in();
        wait_drain("drain_random");
        rand_ready = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;

        // Reset while the multiplier is running: run abandoned, no result
        push_req(32'd11, 32'd13, 4'd5, 1'b0, fr);
        idle_in();
        guard = 0;
        while (!busy && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("reset_run_busy_seen", EW'(busy), EW'(1));
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_reset_outputs();
        @(posedge clk);
        #1;
        check("rst_edge_out_valid", EW'(out_valid), EW'(0));
        @(negedge clk);
        reset = 1'b1;
        snap = start_cnt;
        repeat (30) @(negedge clk);
        #3;
        check("post_reset_no_start",     EW'(start_cnt - snap), EW'(0));
        check("post_reset_no_out_valid", EW'(out_valid),        EW'(0));

`ifdef MULT_REQ_TIMEOUT_EN
        // Multiplier never answers: watchdog drops the request and flags err
        mul_stuck = 1'b1;
        push_req(32'd2, 32'd2, 4'd3, 1'b0, fr);
        idle_in();
        guard = 0;
        while (!start && guard < 20) begin
            @(negedge clk);
            #3;
            guard++;
        end
        check("tmo_start_seen", EW'(start), EW'(1));
        repeat (TIMEOUT_CYC - 2) @(negedge clk);
        #3;
        check("tmo_err_not_early", EW'(err), EW'(0));
        repeat (6) @(negedge clk);
        #3;
        check("tmo_err_set",      EW'(err),       EW'(1));
        check("tmo_no_out_valid", EW'(out_valid), EW'(0));
        check("tmo_fifo_popped",  EW'(in_ready),  EW'(1));
        check("tmo_head_cleared", EW'(a),         EW'(0));
        repeat (10) @(negedge clk);
        #3;
        check("tmo_err_sticky",   EW'(err),       EW'(1));
        mul_stuck = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        #3;
        check("tmo_err_reset",    EW'(err),       EW'(0));
        reset = 1'b1;
        @(negedge clk);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
